// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, grant codes
// and the request/stall bundles exchanged with the picker and hazard unit.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_I,
    ST_ISSUE_D,
    ST_WAIT_I,
    ST_WAIT_D
  } mem_arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } mem_arb_gnt_e;

  typedef struct packed {
    logic if_req;
    logic d_req;
    logic arb_en;
  } mem_arb_in_t;

  typedef struct packed {
    logic stall_if;
    logic stall_mem;
  } mem_arb_out_t;

  function automatic logic is_wait(input mem_arb_state_e s);
    return (s == ST_WAIT_I) || (s == ST_WAIT_D);
  endfunction

  // A grant always lands in the matching ISSUE state; no grant parks in IDLE.
  function automatic mem_arb_state_e gnt_state(input mem_arb_gnt_e g);
    case (g)
      GNT_I:   return ST_ISSUE_I;
      GNT_D:   return ST_ISSUE_D;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data, with the data-streak counter that
// forces a fetch grant once MAX_D_STREAK data grants were given while fetch waited.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_arb_in_t  arb_i,
  output mem_arb_gnt_e gnt_o
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          starve;

  always_comb begin
    starve = arb_i.if_req && (streak_q == STREAK_MAX);
    if (arb_i.d_req && !starve) begin
      gnt_o = GNT_D;
    end else if (arb_i.if_req) begin
      gnt_o = GNT_I;
    end else begin
      gnt_o = GNT_NONE;
    end
  end

  // The streak only moves when a grant is actually taken.
  always_comb begin
    streak_d = streak_q;
    if (arb_i.arb_en) begin
      case (gnt_o)
        GNT_I: streak_d = '0;
        GNT_D: begin
          if (!arb_i.if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end
        default: streak_d = streak_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Define MEM_ARB_PERF_CNT_EN to add 32-bit stall and transfer counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output mem_arb_state_e      dbg_state
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_stall_cnt,
  output logic [31:0]         perf_d_stall_cnt,
  output logic [31:0]         perf_xfer_cnt
`endif
);

  localparam int STRB_W = DATA_W / 8;

  mem_arb_state_e state_q, state_d;
  mem_arb_in_t    arb_in;
  mem_arb_gnt_e   gnt;
  mem_arb_out_t   hz_out;
  logic           rsp_accept;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

  // Responses only count in WAIT_*; a stray rvalid elsewhere is dropped.
  assign rsp_accept = is_wait(state_q) && mem_rvalid;

  always_comb begin
    arb_in.if_req = if_req;
    arb_in.d_req  = d_req;
    arb_in.arb_en = (state_q == ST_IDLE) || rsp_accept;
  end

  mem_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .clk  (clk),
    .reset(reset),
    .arb_i(arb_in),
    .gnt_o(gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:             state_d = gnt_state(gnt);
      ST_ISSUE_I:          if (mem_ready) state_d = ST_WAIT_I;
      ST_ISSUE_D:          if (mem_ready) state_d = ST_WAIT_D;
      ST_WAIT_I, ST_WAIT_D: if (mem_rvalid) state_d = gnt_state(gnt);
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if_valid         = (state_q == ST_WAIT_I) && mem_rvalid;
    d_valid          = (state_q == ST_WAIT_D) && mem_rvalid;
    if_rdata         = mem_rdata;
    d_rdata          = mem_rdata;
    hz_out.stall_if  = if_req & ~if_valid;
    hz_out.stall_mem = d_req & ~d_valid;
  end

  assign stall_if  = hz_out.stall_if;
  assign stall_mem = hz_out.stall_mem;
  assign dbg_state = state_q;

  // Request fields are captured at grant time and held until the next grant.
  always_comb begin
    mem_req_d   = (state_d == ST_ISSUE_I) || (state_d == ST_ISSUE_D);
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if (arb_in.arb_en && (gnt == GNT_D)) begin
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_wstrb_d = d_we ? d_wstrb : '0;
    end else if (arb_in.arb_en && (gnt == GNT_I)) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_wstrb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_d_q, perf_x_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
      perf_x_q  <= '0;
    end else begin
      if (hz_out.stall_if)  perf_if_q <= perf_if_q + 32'd1;
      if (hz_out.stall_mem) perf_d_q  <= perf_d_q + 32'd1;
      if (rsp_accept)       perf_x_q  <= perf_x_q + 32'd1;
    end
  end

  assign perf_if_stall_cnt = perf_if_q;
  assign perf_d_stall_cnt  = perf_d_q;
  assign perf_xfer_cnt     = perf_x_q;
`endif

  // Handshake: a requester holds x_req and its fields from assertion until the
  // cycle its x_valid pulses; in that cycle it may drop x_req or keep it high
  // to present the next request, which is arbitrated immediately.
  a_if_held: assert property (@(posedge clk) disable iff (reset)
    ((state_q == ST_ISSUE_I) || ((state_q == ST_WAIT_I) && !mem_rvalid)) |-> if_req);
  a_d_held: assert property (@(posedge clk) disable iff (reset)
    ((state_q == ST_ISSUE_D) || ((state_q == ST_WAIT_D) && !mem_rvalid)) |-> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch-only, collision, starvation,
// delayed-ready store and reset-during-wait scenarios.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] G_I = 8'd1;
  localparam logic [7:0] G_D = 8'd2;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  mem_arb_state_e    dbg_state;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]       perf_if_stall_cnt;
  logic [31:0]       perf_d_stall_cnt;
  logic [31:0]       perf_xfer_cnt;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         grants;
  bit         in_wait;
  bit         done;
  logic [7:0] g_got;
  logic [7:0] g_exp;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_D_STREAK(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .dbg_state (dbg_state)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_if_stall_cnt(perf_if_stall_cnt),
    .perf_d_stall_cnt (perf_d_stall_cnt),
    .perf_xfer_cnt    (perf_xfer_cnt)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req     = 1'b0;
    if_addr    = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    d_wstrb    = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset();
    #4;
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_valids", 64'({if_valid, d_valid}), 64'd0);

    // Fetch only, ready/rvalid immediate
    cyc();
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    #4;
    check("f_c0_stall_if", 64'(stall_if), 64'd1);
    check("f_c0_mem_req", 64'(mem_req), 64'd0);
    cyc();
    #4;
    check("f_c1_mem_req", 64'(mem_req), 64'd1);
    check("f_c1_mem_addr", 64'(mem_addr), 64'h100);
    check("f_c1_we_strb", 64'({mem_we, mem_wstrb}), 64'd0);
    check("f_c1_stall_if", 64'(stall_if), 64'd1);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    #1;
    check("f_c2_if_valid", 64'(if_valid), 64'd1);
    check("f_c2_if_rdata", 64'(if_rdata), 64'h00500093);
    check("f_c2_stall_if", 64'(stall_if), 64'd0);
    if_req = 1'b0;
    #3;
    cyc();
    mem_rvalid = 1'b0;
    #4;
    check("f_c3_mem_req", 64'(mem_req), 64'd0);
    check("f_c3_state", 64'(dbg_state), 64'(ST_IDLE));

    // Collision: data first, then fetch
    do_reset();
    cyc();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
    mem_ready = 1'b1;
    #4;
    check("c_c0_stalls", 64'({stall_if, stall_mem}), 64'd3);
    cyc();
    #4;
    check("c_c1_mem_req", 64'(mem_req), 64'd1);
    check("c_c1_mem_addr", 64'(mem_addr), 64'h2000);
    check("c_c1_we_strb", 64'({mem_we, mem_wstrb}), 64'd0);
    check("c_c1_stall_if", 64'(stall_if), 64'd1);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    #1;
    check("c_c2_valids", 64'({if_valid, d_valid}), 64'd1);
    check("c_c2_d_rdata", 64'(d_rdata), 64'h11223344);
    check("c_c2_stalls", 64'({stall_if, stall_mem}), 64'd2);
    d_req = 1'b0;
    #3;
    cyc();
    mem_rvalid = 1'b0;
    #4;
    check("c_c3_mem_req", 64'(mem_req), 64'd1);
    check("c_c3_mem_addr", 64'(mem_addr), 64'h104);
    check("c_c3_stall_if", 64'(stall_if), 64'd1);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
    #1;
    check("c_c4_valids", 64'({if_valid, d_valid}), 64'd2);
    check("c_c4_if_rdata", 64'(if_rdata), 64'h13);
    if_req = 1'b0;
    #3;
    cyc();
    mem_rvalid = 1'b0;
    #4;
    check("c_c5_state", 64'(dbg_state), 64'(ST_IDLE));
    check("c_c5_mem_req", 64'(mem_req), 64'd0);
`ifdef MEM_ARB_PERF_CNT_EN
    check("perf_xfer", 64'(perf_xfer_cnt), 64'd2);
    check("perf_if_stall", 64'(perf_if_stall_cnt), 64'd4);
    check("perf_d_stall", 64'(perf_d_stall_cnt), 64'd2);
`endif

    // Starvation: grants must follow D,D,D,D,I,D
    do_reset();
    exp_q = {G_D, G_D, G_D, G_D, G_I, G_D};
    cyc();
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
    #4;
    grants = 0; in_wait = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      cyc();
      mem_rvalid = in_wait;
      if (in_wait && grants == 6) begin
        if_req = 1'b0;
        d_req  = 1'b0;
        done   = 1'b1;
      end
      #4;
      in_wait = 1'b0;
      if (mem_req && exp_q.size() > 0) begin
        g_got = (mem_addr == 32'h3000) ? G_D : G_I;
        g_exp = exp_q.pop_front();
        check($sformatf("s_grant%0d", grants), 64'(g_got), 64'(g_exp));
        grants++;
        in_wait = 1'b1;
      end
    end
    check("s_grant_count", 64'(grants), 64'd6);
    cyc();
    mem_rvalid = 1'b0;
    #4;
    check("s_end_state", 64'(dbg_state), 64'(ST_IDLE));

    // Store with mem_ready held off for three cycles
    do_reset();
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'h3;
    mem_ready = 1'b0;
    #4;
    check("w_c0_stall_mem", 64'(stall_mem), 64'd1);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      #4;
      check($sformatf("w_c%0d_req_we", c), 64'({mem_req, mem_we}), 64'd3);
      check($sformatf("w_c%0d_addr", c), 64'(mem_addr), 64'h2004);
      check($sformatf("w_c%0d_wdata", c), 64'(mem_wdata), 64'hDEADBEEF);
      check($sformatf("w_c%0d_wstrb", c), 64'(mem_wstrb), 64'h3);
    end
    cyc();
    mem_ready = 1'b1;
    #4;
    check("w_c4_mem_req", 64'(mem_req), 64'd1);
    cyc();
    mem_ready = 1'b0;
    #4;
    check("w_c5_mem_req", 64'(mem_req), 64'd0);
    check("w_c5_d_valid", 64'(d_valid), 64'd0);
    check("w_c5_state", 64'(dbg_state), 64'(ST_WAIT_D));
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    #1;
    check("w_c6_d_valid", 64'(d_valid), 64'd1);
    check("w_c6_stall_mem", 64'(stall_mem), 64'd0);
    d_req = 1'b0; d_we = 1'b0;
    #3;
    cyc();
    mem_rvalid = 1'b0;
    #4;
    check("w_c7_state", 64'(dbg_state), 64'(ST_IDLE));

    // Reset while in WAIT_D; the late response must be discarded
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008; mem_ready = 1'b1;
    #4;
    cyc();
    #4;
    check("r_c1_mem_req", 64'(mem_req), 64'd1);
    cyc();
    mem_ready = 1'b0;
    #4;
    check("r_c2_state", 64'(dbg_state), 64'(ST_WAIT_D));
    reset = 1'b1;
    d_req = 1'b0;
    cyc();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    check("r_c3_d_valid", 64'(d_valid), 64'd0);
    check("r_c3_state", 64'(dbg_state), 64'(ST_IDLE));
    check("r_c3_mem_req", 64'(mem_req), 64'd0);
    #3;
    cyc();
    mem_rvalid = 1'b0;
    #4;
    check("r_c4_mem_req", 64'(mem_req), 64'd0);
    check("r_c4_state", 64'(dbg_state), 64'(ST_IDLE));

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified instruction/data memory port between the fetch stage (read-only) and the memory stage (load/store) of the 5-stage pipeline.
- Sequences one outstanding memory transaction at a time.
- Raises per-stage stall requests that are ORed into the hazard unit's StallF/StallD and whole-pipeline stall.
- Data requests normally win arbitration; a streak counter prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch needs an instruction; held until if_valid.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_valid  out  1  one-cycle pulse: instruction returned.
- if_rdata  out  DATA_W  instruction, valid with if_valid.
- d_req  in  1  load/store request; held until d_valid.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  byte strobes.
- d_valid  out  1  pulse: load data / store ack.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_wstrb  out  DATA_W/8  strobes (0 for reads).
- mem_ready  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  response/write-ack (exactly one per accepted request).
- mem_rdata  in  DATA_W  read data.
- stall_if  out  1  to hazard unit.
- stall_mem  out  1  to hazard unit.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: FSM IDLE, streak=0, mem_req=0, mem_we=0, mem_addr/wdata/wstrb=0, if_valid=d_valid=0. stall_if/stall_mem follow the combinational rule below.
- FSM states: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D.
- Arbitration (evaluated in IDLE, and in WAIT_* on the mem_rvalid cycle):
  - Choose D if d_req and not (if_req and streak==MAX_D_STREAK).
  - Otherwise choose I if if_req.
  - Otherwise go to IDLE.
  - Choice registers the request fields into mem_* and enters ISSUE_x next cycle.
- ISSUE_x:
  - mem_req=1; fields held stable until mem_ready.
  - On mem_ready go to WAIT_x and drop mem_req next cycle.
- WAIT_x:
  - On mem_rvalid, pulse x_valid combinationally the same cycle; x_rdata = mem_rdata.
  - Re-arbitrate in the same cycle, so back-to-back transactions are possible.
  - mem_rvalid is never sampled in IDLE or ISSUE_*; it is ignored there.
- Streak counter:
  - Increments on a D grant while if_req=1, saturating at MAX_D_STREAK.
  - Clears on any I grant, and on a D grant with if_req=0.
- Stalls: stall_if = if_req & ~if_valid; stall_mem = d_req & ~d_valid (combinational).
- Requester rule: a request seen in the cycle after its x_valid is a new request.
- Minimum latency with ready/rvalid asserted immediately: request visible at N, mem_req at N+1, rvalid at N+2 earliest, x_valid at N+2.
- Boundaries:
  - Simultaneous if_req/d_req in IDLE: D wins unless streak is saturated.
  - Requester dropping req mid-transaction is illegal (assertion).
  - reset during ISSUE/WAIT: immediate return to IDLE; the late response is discarded.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs perf_if_stall_cnt, perf_d_stall_cnt, and perf_xfer_cnt, each 32 bits.
  - perf_if_stall_cnt increments per cycle with stall_if=1.
  - perf_d_stall_cnt increments per cycle with stall_mem=1.
  - perf_xfer_cnt increments per mem_rvalid accepted in WAIT_*.
  - All clear on reset; all wrap at 2^32.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum;
  - mem_arb_in/mem_arb_out structs, matching the hazard_io port style;
  - the grant enum {GNT_NONE, GNT_I, GNT_D}.
- Sub-module mem_arb_pick: combinational grant choice plus the streak counter register; FSM and datapath registers stay in the top.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1, addr 0x100; ready and rvalid immediate.
  - Response: mem_req at cycle 1; if_valid at cycle 2 with rdata 0x00500093; stall_if=1 in cycles 0-1.
- Collision:
  - Stimulus: if_req and d_req asserted same cycle (load 0x2000).
  - Response: data issues first, fetch second; stall_if held throughout.
- Starvation:
  - Stimulus: d_req continuously with MAX_D_STREAK=4 and if_req held.
  - Response: grant sequence D,D,D,D,I,D...
- Store:
  - Stimulus: d_we=1, addr 0x2004, wdata 0xDEADBEEF, wstrb 0x3; mem_ready delayed 3 cycles.
  - Response: mem fields stable all 3 cycles; d_valid on ack.
- Reset in WAIT_D, then rvalid next cycle:
  - Response: no d_valid pulse; FSM in IDLE; mem_req=0.
- With MEM_ARB_PERF_CNT_EN defined, after the collision test:
  - Response: perf_xfer_cnt=2; perf_if_stall_cnt equals the cycle count of stall_if=1.
